// File: rtl/mem_noc_pkg.sv
// mem_noc_pkg: tile memory NoC message format, responder states and flit-count helper.
package mem_noc_pkg;

    localparam int NOC_DATA_WIDTH      = 512;
    localparam int BYTES_PER_FLIT      = NOC_DATA_WIDTH / 8;
    localparam int FLIT_OFF_W          = $clog2(BYTES_PER_FLIT);
    localparam int MSG_CHIP_WIDTH      = 14;
    localparam int MSG_XY_WIDTH        = 8;
    localparam int MSG_LEN_WIDTH       = 8;
    localparam int MSG_TYPE_WIDTH      = 8;
    localparam int MSG_ADDR_WIDTH      = 48;
    localparam int MSG_DATA_SIZE_WIDTH = 12;
    localparam int HDR_USED_W = 2 * (MSG_CHIP_WIDTH + 2 * MSG_XY_WIDTH) + MSG_LEN_WIDTH
                              + MSG_TYPE_WIDTH + MSG_ADDR_WIDTH + MSG_DATA_SIZE_WIDTH;

    typedef enum logic [MSG_TYPE_WIDTH-1:0] {
        STORE_REQ = 8'd1,
        LOAD_REQ  = 8'd2,
        STORE_ACK = 8'd3,
        LOAD_RESP = 8'd4
    } msg_type_e;

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_ACK, RD_HDR, RD_ISSUE, RD_SEND, DROP
    } state_e;

    // Fields are laid out MSB-first so the struct maps directly onto a flit.
    typedef struct packed {
        logic [MSG_CHIP_WIDTH-1:0]             dst_chip;
        logic [MSG_XY_WIDTH-1:0]               dst_x;
        logic [MSG_XY_WIDTH-1:0]               dst_y;
        logic [MSG_LEN_WIDTH-1:0]              msg_len;
        logic [MSG_TYPE_WIDTH-1:0]             msg_type;
        logic [MSG_CHIP_WIDTH-1:0]             src_chip;
        logic [MSG_XY_WIDTH-1:0]               src_x;
        logic [MSG_XY_WIDTH-1:0]               src_y;
        logic [MSG_ADDR_WIDTH-1:0]             addr;
        logic [MSG_DATA_SIZE_WIDTH-1:0]        size;
        logic [NOC_DATA_WIDTH-HDR_USED_W-1:0]  rsvd;
    } mem_noc_hdr_t;

    function automatic logic [MSG_LEN_WIDTH-1:0] flit_count(input logic [MSG_DATA_SIZE_WIDTH-1:0] size);
        logic [MSG_DATA_SIZE_WIDTH:0] t;
        t = {1'b0, size} + (MSG_DATA_SIZE_WIDTH+1)'(BYTES_PER_FLIT - 1);
        return MSG_LEN_WIDTH'(t >> FLIT_OFF_W);
    endfunction

endpackage

// File: rtl/mem_noc_hdr_codec.sv
// mem_noc_hdr_codec: unpacks request headers and packs response headers sourced from this tile.
module mem_noc_hdr_codec
    import mem_noc_pkg::*;
#(
    parameter int MY_X = 0,
    parameter int MY_Y = 0
) (
    input  logic [NOC_DATA_WIDTH-1:0]      req_flit,
    output mem_noc_hdr_t                   req_hdr,
    input  msg_type_e                      rsp_type,
    input  logic [MSG_LEN_WIDTH-1:0]       rsp_len,
    input  logic [MSG_CHIP_WIDTH-1:0]      dst_chip,
    input  logic [MSG_XY_WIDTH-1:0]        dst_x,
    input  logic [MSG_XY_WIDTH-1:0]        dst_y,
    input  logic [MSG_ADDR_WIDTH-1:0]      addr,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] size,
    output logic [NOC_DATA_WIDTH-1:0]      rsp_flit
);

    mem_noc_hdr_t rsp_hdr;

    assign req_hdr  = req_flit;
    assign rsp_flit = rsp_hdr;

    always_comb begin
        rsp_hdr          = '0;
        rsp_hdr.dst_chip = dst_chip;
        rsp_hdr.dst_x    = dst_x;
        rsp_hdr.dst_y    = dst_y;
        rsp_hdr.msg_len  = rsp_len;
        rsp_hdr.msg_type = rsp_type;
        rsp_hdr.src_x    = MSG_XY_WIDTH'(MY_X);
        rsp_hdr.src_y    = MSG_XY_WIDTH'(MY_Y);
        rsp_hdr.addr     = addr;
        rsp_hdr.size     = size;
    end

endmodule

// File: rtl/noc_mem_responder.sv
// noc_mem_responder: NoC memory endpoint executing store/load requests against a 1-cycle SRAM
// and returning STORE_ACK / LOAD_RESP messages, one message in flight at a time.
module noc_mem_responder
    import mem_noc_pkg::*;
#(
    parameter int MY_X      = 0,
    parameter int MY_Y      = 0,
    parameter int MEM_IDX_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      noc0_mem_val,
    input  logic [NOC_DATA_WIDTH-1:0] noc0_mem_data,
    output logic                      mem_noc0_rdy,
    output logic                      mem_noc0_val,
    output logic [NOC_DATA_WIDTH-1:0] mem_noc0_data,
    input  logic                      noc0_mem_rdy,
    output logic                      mem_wr_en,
    output logic [MEM_IDX_W-1:0]      mem_wr_idx,
    output logic [NOC_DATA_WIDTH-1:0] mem_wr_data,
    output logic                      mem_rd_en,
    output logic [MEM_IDX_W-1:0]      mem_rd_idx,
    input  logic [NOC_DATA_WIDTH-1:0] mem_rd_data
);

    state_e                         state_q, state_d;
    logic [MEM_IDX_W-1:0]           idx_q, idx_d;
    logic [MSG_LEN_WIDTH-1:0]       cnt_q, cnt_d;
    logic                           rdy_q, rdy_d;
    logic                           val_q, val_d;
    logic                           rd_pass_q, rd_pass_d;
    logic [NOC_DATA_WIDTH-1:0]      data_q, data_d;
    logic [MSG_TYPE_WIDTH-1:0]      type_q, type_d;
    logic [MSG_CHIP_WIDTH-1:0]      chip_q, chip_d;
    logic [MSG_XY_WIDTH-1:0]        x_q, x_d, y_q, y_d;
    logic [MSG_ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [MSG_DATA_SIZE_WIDTH-1:0] size_q, size_d;
    mem_noc_hdr_t                   in_hdr;
    logic [NOC_DATA_WIDTH-1:0]      rsp_flit;
    logic                           in_acc, out_acc, hdr_acc;

    assign in_acc  = rdy_q && noc0_mem_val;
    assign out_acc = val_q && noc0_mem_rdy;
    assign hdr_acc = in_acc && state_q == IDLE;

    assign mem_noc0_rdy  = rdy_q;
    assign mem_noc0_val  = val_q;
    // First RD_SEND cycle forwards the SRAM output register; afterwards the captured copy holds it.
    assign mem_noc0_data = rd_pass_q ? mem_rd_data : data_q;
    assign mem_wr_en     = in_acc && state_q == WR_DATA;
    assign mem_wr_idx    = idx_q;
    assign mem_wr_data   = mem_wr_en ? noc0_mem_data : '0;
    assign mem_rd_en     = state_q == RD_ISSUE;
    assign mem_rd_idx    = idx_q;

    mem_noc_hdr_codec #(.MY_X(MY_X), .MY_Y(MY_Y)) u_codec (
        .req_flit (noc0_mem_data),
        .req_hdr  (in_hdr),
        .rsp_type (type_d == LOAD_REQ ? LOAD_RESP : STORE_ACK),
        .rsp_len  (type_d == LOAD_REQ ? flit_count(size_d) : '0),
        .dst_chip (chip_d),
        .dst_x    (x_d),
        .dst_y    (y_d),
        .addr     (addr_d),
        .size     (size_d),
        .rsp_flit (rsp_flit)
    );

    always_comb begin
        type_d = hdr_acc ? in_hdr.msg_type : type_q;
        chip_d = hdr_acc ? in_hdr.src_chip : chip_q;
        x_d    = hdr_acc ? in_hdr.src_x : x_q;
        y_d    = hdr_acc ? in_hdr.src_y : y_q;
        addr_d = hdr_acc ? in_hdr.addr : addr_q;
        size_d = hdr_acc ? in_hdr.size : size_q;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        val_d     = val_q;
        data_d    = mem_noc0_data;
        rd_pass_d = 1'b0;
        case (state_q)
            IDLE: if (in_acc) begin
                idx_d = MEM_IDX_W'(in_hdr.addr >> FLIT_OFF_W);
                cnt_d = in_hdr.msg_len;
                if (in_hdr.msg_type == STORE_REQ) begin
                    state_d = in_hdr.msg_len != '0 ? WR_DATA : WR_ACK;
                    val_d   = in_hdr.msg_len == '0;
                    data_d  = in_hdr.msg_len == '0 ? rsp_flit : mem_noc0_data;
                end else if (in_hdr.msg_type == LOAD_REQ) begin
                    state_d = RD_HDR;
                    cnt_d   = flit_count(in_hdr.size);
                    val_d   = 1'b1;
                    data_d  = rsp_flit;
                end else begin
                    state_d = in_hdr.msg_len != '0 ? DROP : IDLE;
                end
            end
            WR_DATA: if (in_acc) begin
                idx_d = idx_q + 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d = WR_ACK;
                    val_d   = 1'b1;
                    data_d  = rsp_flit;
                end
            end
            WR_ACK: if (out_acc) begin
                state_d = IDLE;
                val_d   = 1'b0;
            end
            RD_HDR: if (out_acc) begin
                state_d = cnt_q == '0 ? IDLE : RD_ISSUE;
                val_d   = 1'b0;
            end
            RD_ISSUE: begin
                state_d   = RD_SEND;
                val_d     = 1'b1;
                rd_pass_d = 1'b1;
            end
            RD_SEND: if (out_acc) begin
                state_d = cnt_q == 1 ? IDLE : RD_ISSUE;
                val_d   = 1'b0;
                idx_d   = idx_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
            end
            DROP: if (in_acc) begin
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == 1 ? IDLE : DROP;
            end
            default: state_d = IDLE;
        endcase
        rdy_d = state_d == IDLE || state_d == WR_DATA || state_d == DROP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            rdy_q     <= 1'b0;
            val_q     <= 1'b0;
            rd_pass_q <= 1'b0;
            data_q    <= '0;
            type_q    <= '0;
            chip_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            size_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rdy_q     <= rdy_d;
            val_q     <= val_d;
            rd_pass_q <= rd_pass_d;
            data_q    <= data_d;
            type_q    <= type_d;
            chip_q    <= chip_d;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
        end
    end

endmodule

// File: tb/tb_noc_mem_responder.sv
// tb_noc_mem_responder: directed store/load/drop/reset scenarios against a behavioural 1-cycle SRAM.
module tb_noc_mem_responder;
    import mem_noc_pkg::*;

    localparam int W = NOC_DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          noc0_mem_val = 1'b0;
    logic [W-1:0]  noc0_mem_data = '0;
    logic          mem_noc0_rdy;
    logic          mem_noc0_val;
    logic [W-1:0]  mem_noc0_data;
    logic          noc0_mem_rdy = 1'b0;
    logic          mem_wr_en;
    logic [9:0]    mem_wr_idx;
    logic [W-1:0]  mem_wr_data;
    logic          mem_rd_en;
    logic [9:0]    mem_rd_idx;
    logic [W-1:0]  mem_rd_data;
    logic [W-1:0]  mem [0:1023];
    int            wr_cnt = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    noc_mem_responder #(.MY_X(3), .MY_Y(1), .MEM_IDX_W(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .noc0_mem_val  (noc0_mem_val),
        .noc0_mem_data (noc0_mem_data),
        .mem_noc0_rdy  (mem_noc0_rdy),
        .mem_noc0_val  (mem_noc0_val),
        .mem_noc0_data (mem_noc0_data),
        .noc0_mem_rdy  (noc0_mem_rdy),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_idx    (mem_wr_idx),
        .mem_wr_data   (mem_wr_data),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_idx    (mem_rd_idx),
        .mem_rd_data   (mem_rd_data)
    );

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_idx] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_idx];
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    end

    function automatic logic [W-1:0] hdr(input logic [7:0] t, input logic [7:0] len,
                                         input logic [13:0] dchip, input logic [7:0] dx, input logic [7:0] dy,
                                         input logic [13:0] schip, input logic [7:0] sx, input logic [7:0] sy,
                                         input logic [47:0] a, input logic [11:0] sz);
        mem_noc_hdr_t h;
        h = '0;
        h.dst_chip = dchip; h.dst_x = dx; h.dst_y = dy;
        h.msg_len = len; h.msg_type = t;
        h.src_chip = schip; h.src_x = sx; h.src_y = sy;
        h.addr = a; h.size = sz;
        return h;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] f);
        int n = 0;
        noc0_mem_val = 1'b1;
        noc0_mem_data = f;
        while (!mem_noc0_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_rdy", W'(mem_noc0_rdy), W'(1));
        @(negedge clk);
        noc0_mem_val = 1'b0;
        noc0_mem_data = '0;
    endtask

    task automatic recv(output logic [W-1:0] f, output int w);
        w = 0;
        while (!mem_noc0_val && w < 20) begin
            @(negedge clk);
            w++;
        end
        f = mem_noc0_data;
        noc0_mem_rdy = 1'b1;
        @(negedge clk);
        noc0_mem_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] f, a_d, b_d, c_d, d_d;
        int w, wc0;
        a_d = {16{32'hA5A5_0001}};
        b_d = {16{32'hB6B6_0002}};
        c_d = {16{32'hC7C7_0003}};
        d_d = {16{32'hD8D8_0004}};

        repeat (3) @(negedge clk);
        chk("rst_rdy", W'(mem_noc0_rdy), W'(0));
        chk("rst_val", W'(mem_noc0_val), W'(0));
        chk("rst_wr_en", W'(mem_wr_en), W'(0));
        chk("rst_rd_en", W'(mem_rd_en), W'(0));
        chk("rst_data", mem_noc0_data, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", W'(mem_noc0_rdy), W'(1));

        send(hdr(STORE_REQ, 2, 0, 3, 1, 2, 5, 6, 48'h80, 12'd128));
        send(a_d);
        send(b_d);
        chk("st_ack_latency", W'(mem_noc0_val), W'(1));
        recv(f, w);
        chk("st_ack_wait", W'(w), W'(0));
        chk("st_ack_hdr", f, hdr(STORE_ACK, 0, 2, 5, 6, 0, 3, 1, 48'h80, 12'd128));
        chk("st_word2", mem[2], a_d);
        chk("st_word3", mem[3], b_d);
        chk("st_wr_cnt", W'(wr_cnt), W'(2));

        send(hdr(LOAD_REQ, 0, 0, 3, 1, 1, 7, 8, 48'h80, 12'd100));
        recv(f, w);
        chk("ld_hdr_wait", W'(w), W'(0));
        chk("ld_hdr", f, hdr(LOAD_RESP, 2, 1, 7, 8, 0, 3, 1, 48'h80, 12'd100));
        recv(f, w);
        chk("ld_a_wait", W'(w), W'(1));
        chk("ld_a", f, a_d);
        recv(f, w);
        chk("ld_b_wait", W'(w), W'(1));
        chk("ld_b", f, b_d);
        chk("ld_b2b_rdy", W'(mem_noc0_rdy), W'(1));

        send(hdr(LOAD_REQ, 0, 0, 3, 1, 1, 7, 8, 48'h80, 12'd128));
        recv(f, w);
        chk("bp_hdr", f, hdr(LOAD_RESP, 2, 1, 7, 8, 0, 3, 1, 48'h80, 12'd128));
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_val", W'(mem_noc0_val), W'(1));
            chk("bp_hold_data", mem_noc0_data, a_d);
            @(negedge clk);
        end
        recv(f, w);
        chk("bp_a_wait", W'(w), W'(0));
        chk("bp_a", f, a_d);
        recv(f, w);
        chk("bp_b_wait", W'(w), W'(1));
        chk("bp_b", f, b_d);

        wc0 = wr_cnt;
        send(hdr(STORE_REQ, 0, 0, 3, 1, 0, 4, 4, 48'h40, 12'd0));
        chk("st0_ack_latency", W'(mem_noc0_val), W'(1));
        recv(f, w);
        chk("st0_ack", f, hdr(STORE_ACK, 0, 0, 4, 4, 0, 3, 1, 48'h40, 12'd0));
        chk("st0_no_write", W'(wr_cnt), W'(wc0));

        send(hdr(LOAD_REQ, 0, 0, 3, 1, 0, 4, 4, 48'hC0, 12'd0));
        recv(f, w);
        chk("ld0_hdr", f, hdr(LOAD_RESP, 0, 0, 4, 4, 0, 3, 1, 48'hC0, 12'd0));
        chk("ld0_val_done", W'(mem_noc0_val), W'(0));
        chk("ld0_rdy", W'(mem_noc0_rdy), W'(1));

        wc0 = wr_cnt;
        send(hdr(8'd7, 3, 0, 3, 1, 0, 2, 2, 48'h0, 12'd0));
        send(c_d);
        send(d_d);
        send(hdr(STORE_REQ, 0, 0, 3, 1, 0, 2, 2, 48'h1C0, 12'd0));
        @(negedge clk);
        chk("drop_no_rsp", W'(mem_noc0_val), W'(0));
        chk("drop_no_write", W'(wr_cnt), W'(wc0));
        send(hdr(STORE_REQ, 1, 0, 3, 1, 0, 9, 9, 48'h100, 12'd64));
        send(c_d);
        recv(f, w);
        chk("drop_next_ack", f, hdr(STORE_ACK, 0, 0, 9, 9, 0, 3, 1, 48'h100, 12'd64));
        chk("drop_next_word4", mem[4], c_d);

        send(hdr(STORE_REQ, 2, 0, 3, 1, 0, 6, 6, 48'h140, 12'd128));
        send(d_d);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy", W'(mem_noc0_rdy), W'(0));
        chk("mid_rst_val", W'(mem_noc0_val), W'(0));
        chk("mid_rst_wr_en", W'(mem_wr_en), W'(0));
        chk("mid_rst_rd_en", W'(mem_rd_en), W'(0));
        chk("mid_rst_data", mem_noc0_data, '0);
        chk("mid_rst_wr_idx", W'(mem_wr_idx), W'(0));
        chk("mid_rst_rd_idx", W'(mem_rd_idx), W'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_ack", W'(mem_noc0_val), W'(0));
        chk("mid_rst_idle_rdy", W'(mem_noc0_rdy), W'(1));
        chk("mid_rst_word5", mem[5], d_d);
        send(hdr(LOAD_REQ, 0, 0, 3, 1, 0, 6, 6, 48'h140, 12'd64));
        recv(f, w);
        chk("post_rst_hdr", f, hdr(LOAD_RESP, 1, 0, 6, 6, 0, 3, 1, 48'h140, 12'd64));
        recv(f, w);
        chk("post_rst_wait", W'(w), W'(1));
        chk("post_rst_data", f, d_d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
